fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the single-cycle and upcoming pipelined CPU. It owns the program counter and issues sequential word fetches to a synchronous instruction memory. Fetched {pc, instr} pairs are buffered in a small queue for the decode stage, behind a valid/ready handshake. It also supports redirect (branch/jump) with queue flush, replacing the externally stepped address input with a self-sequencing PC.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_unit_sync_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants, types and helpers for the instruction-fetch front end.
package fetch_pkg;

  // Every instruction is one 32-bit word.
  localparam int INSTR_BYTES = 4;

  // Default widths for code that passes fetch entries around.
  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step. It is computed wide; callers truncate to their
  // address width, so the PC wraps silently modulo 2^ADDR_W.
  function automatic logic [63:0] pc_incr(input logic [63:0] pc);
    return pc + 64'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Circular-buffer FIFO with synchronous flush. Any DEPTH >= 2 works
// (pointers wrap explicitly, no power-of-two assumption).
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_step(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage entries; cleared on reset so the head reads zero afterwards.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst)
          mem_reg[gi] <= '0;
        else if (!flush && do_push && wr_ptr_reg == PTR_W'(gi))
          mem_reg[gi] <= push_data;
      end
    end
  endgenerate

  // Pointer and occupancy bookkeeping; flush beats push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_step(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_step(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: self-sequencing PC, credit-based request
// issue into a synchronous memory, and a queue of {pc, instr} for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] inflight_pc_reg;
  logic              inflight_reg;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              credit_ok;
  entry_t            push_entry;
  entry_t            head_entry;

  // A slot is reserved for every outstanding response, so a response is
  // never dropped. The full check is redundant with the credit sum and
  // only guards against a corrupted count.
  assign credit_ok = ({1'b0, fifo_count} + (CNT_W+1)'(inflight_reg))
                     < (CNT_W+1)'(DEPTH);
  assign imem_req  = !rst && !redirect_valid && credit_ok && !fifo_full;
  assign imem_addr = pc_reg;
  assign pc_o      = pc_reg;

  assign push_entry = '{pc: inflight_pc_reg, instr: imem_rdata};
  assign out_valid  = !fifo_empty;
  assign out_pc     = head_entry.pc;
  assign out_instr  = head_entry.instr;

  // PC and in-flight tracking; reset beats redirect, redirect beats issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else if (redirect_valid) begin
      pc_reg       <= redirect_pc & ~ADDR_W'(INSTR_BYTES-1);
      inflight_reg <= 1'b0;
    end else begin
      inflight_reg <= imem_req;
      if (imem_req) begin
        pc_reg          <= ADDR_W'(pc_incr(64'(pc_reg)));
        inflight_pc_reg <= pc_reg;
      end
    end
  end

  // Redirect flushes the queue and also suppresses the stale response push.
  sync_fifo #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight_reg),
    .push_data(push_entry),
    .pop      (out_valid && out_ready),
    .flush    (redirect_valid),
    .pop_data (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a 32-bit instance with a synchronous
// memory model, plus an 8-bit instance for PC wrap-around.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] pc_o;

  logic        w_req;
  logic [7:0]  w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [7:0]  w_pc;
  logic [31:0] w_instr;
  logic [7:0]  w_pc_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .pc_o(pc_o)
  );

  fetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(3), .RESET_PC(8'hF8)) dut_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(1'b0), .redirect_pc(8'h00),
    .out_valid(w_valid), .out_ready(1'b1), .out_pc(w_pc),
    .out_instr(w_instr), .pc_o(w_pc_o)
  );

  // Synchronous instruction memories: data = addr ^ A5A5_0000, one cycle late.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem_addr ^ 32'hA5A5_0000;
    if (w_req)    w_rdata    <= {24'h0, w_addr} ^ 32'hA5A5_0000;
  end

  task automatic hold_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%0h exp=0", pc_o); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%0h exp=0", imem_addr); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%0h exp=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%0h exp=0", out_instr); end
    $display("test_reset done");
  endtask

  task automatic test_sequential();
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k == 0) begin
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL seq_first_req got=%0b exp=1", imem_req); end
      end
      checks++;
      if (out_valid !== (k >= 2)) begin
        failures++; $display("FAIL seq_valid k=%0d got=%0b exp=%0b", k, out_valid, (k >= 2));
      end
      if (k >= 2) begin
        checks++;
        if (out_pc !== 32'(4 * (k - 2)) || out_instr !== (32'(4 * (k - 2)) ^ 32'hA5A5_0000)) begin
          failures++;
          $display("FAIL seq_data k=%0d got=%0h/%0h exp=%0h", k, out_pc, out_instr, 4 * (k - 2));
        end
      end
      $display("seq cycle %0d valid=%0b pc=%0h", k, out_valid, out_pc);
    end
  endtask

  task automatic test_backpressure();
    int reqs;
    int n;
    logic [31:0] exp_pc;
    out_ready = 1'b0;
    hold_reset(2);
    rst = 1'b0;
    reqs = 0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (imem_req) reqs++;
    end
    checks++; if (reqs != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", reqs); end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_low got=%0b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%0b/%0h exp=1/0", out_valid, out_pc); end
    @(negedge clk);
    out_ready = 1'b1;
    n = 0; exp_pc = 32'h0;
    for (int i = 0; i < 30 && n < 8; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (i == 0) begin
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_still_full got=%0b exp=0", imem_req); end
      end
      if (i == 1) begin
        checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL bp_restart got=%0b exp=1", imem_req); end
      end
      if (out_valid) begin
        checks++;
        if (out_pc !== exp_pc) begin failures++; $display("FAIL bp_drain got=%0h exp=%0h", out_pc, exp_pc); end
        $display("drain pc=%0h", out_pc);
        exp_pc = exp_pc + 32'd4;
        n++;
      end
    end
    checks++; if (n != 8) begin failures++; $display("FAIL bp_drain_timeout got=%0d exp=8", n); end
  endtask

  task automatic test_redirect();
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rd_pre_req got=%0b exp=1", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rd_no_req got=%0b exp=0", imem_req); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_flush_valid got=%0b exp=0", out_valid); end
    checks++; if (imem_addr !== 32'h100 || imem_req !== 1'b1) begin failures++; $display("FAIL rd_new_fetch got=%0h/%0b exp=100/1", imem_addr, imem_req); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_stale got=%0b/%0h exp=0", out_valid, out_pc); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'hA5A5_0100) begin failures++; $display("FAIL rd_first got=%0b/%0h/%0h exp=1/100/a5a50100", out_valid, out_pc, out_instr); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin failures++; $display("FAIL rd_second got=%0b/%0h exp=1/104", out_valid, out_pc); end
    $display("redirect to 100 observed head pc=%0h", out_pc);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'h200 || pc_o !== 32'h200) begin failures++; $display("FAIL misaligned got=%0h/%0h exp=200", imem_addr, pc_o); end
    $display("misaligned redirect addr=%0h", imem_addr);
  endtask

  task automatic test_reset_mid();
    bit stalled;
    @(negedge clk);
    out_ready = 1'b0;
    stalled = 1'b0;
    for (int i = 0; i < 20 && !stalled; i++) begin
      @(negedge clk); #1;
      if (!imem_req) stalled = 1'b1;
    end
    checks++; if (!stalled) begin failures++; $display("FAIL rm_stall_timeout got=0 exp=1"); end
    @(negedge clk);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    #1;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rm_req_r0 got=%0b exp=0", imem_req); end
    @(negedge clk); #1;
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0 || pc_o !== 32'h0) begin failures++; $display("FAIL rm_in_reset got=%0b/%0b/%0h exp=0/0/0", out_valid, imem_req, pc_o); end
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++; if (pc_o !== 32'h0 || imem_req !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL rm_release got=%0h/%0b/%0b exp=0/1/0", pc_o, imem_req, out_valid); end
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin failures++; $display("FAIL rm_resume got=%0b/%0h exp=1/0", out_valid, out_pc); end
    $display("reset mid-op resumed pc=%0h", out_pc);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_w [4];
    exp_w[0] = 8'hF8; exp_w[1] = 8'hFC; exp_w[2] = 8'h00; exp_w[3] = 8'h04;
    hold_reset(2);
    #1;
    checks++; if (w_pc_o !== 8'hF8) begin failures++; $display("FAIL wrap_reset_pc got=%0h exp=f8", w_pc_o); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k >= 2) begin
        checks++;
        if (w_valid !== 1'b1 || w_pc !== exp_w[k-2] || w_instr !== ({24'h0, exp_w[k-2]} ^ 32'hA5A5_0000)) begin
          failures++; $display("FAIL wrap_seq k=%0d got=%0b/%0h exp=1/%0h", k, w_valid, w_pc, exp_w[k-2]);
        end
        $display("wrap pc=%0h", w_pc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
